// File: rtl/alu_muldiv_pkg.sv
// Shared op codes, FSM state encodings and op-class helpers for the
// multi-cycle ALU with RV32M multiply/divide.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'b00000,
    OP_SLL    = 5'b00001,
    OP_SLT    = 5'b00010,
    OP_SLTU   = 5'b00011,
    OP_XOR    = 5'b00100,
    OP_SRL    = 5'b00101,
    OP_OR     = 5'b00110,
    OP_AND    = 5'b00111,
    OP_SUB    = 5'b01000,
    OP_SRA    = 5'b01101,
    OP_MUL    = 5'b10000,
    OP_MULH   = 5'b10001,
    OP_MULHSU = 5'b10010,
    OP_MULHU  = 5'b10011,
    OP_DIV    = 5'b10100,
    OP_DIVU   = 5'b10101,
    OP_REM    = 5'b10110,
    OP_REMU   = 5'b10111
  } alu_op_e;

  typedef logic [1:0] state_e;
  localparam state_e IDLE = 2'd0;
  localparam state_e BUSY = 2'd1;
  localparam state_e DONE = 2'd2;

  // M ops are 10xxx; 11xxx is an unused code space that yields 0
  function automatic logic is_mdu(input logic [4:0] op);
    return op[4] & ~op[3];
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return is_mdu(op) & op[2];
  endfunction

endpackage

// File: rtl/alu_muldiv_base.sv
// Combinational single-cycle datapath for the RV32I base ALU ops.
module alu_base
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_y
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_b[SHW-1:0];

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_SLT:  o_y = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OP_SLTU: o_y = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      OP_SLL:  o_y = i_a << w_shamt;
      OP_SRL:  o_y = i_a >> w_shamt;
      OP_SRA:  o_y = $unsigned($signed(i_a) >>> w_shamt);
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU: base ops in one cycle, RV32M mul/div iterated one radix-2
// step per cycle, behind valid/ready handshakes with a held registered result.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      ALUControl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e            r_state;
  logic [SHW-1:0]    r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [4:0]        r_op;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_result;
  logic              r_zero;
  logic              r_out_valid;

  logic [XLEN-1:0]   w_base;
  logic              w_accept;
  logic              w_is_mdu;
  logic              w_is_div;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN-1:0]   w_load_res;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_trial;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_mdu_res;

  alu_base #(.XLEN(XLEN)) u_base (
    .i_op (ALUControl),
    .i_a  (SrcA),
    .i_b  (SrcB),
    .o_y  (w_base)
  );

  assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign w_accept  = in_valid & in_ready & ~flush;
  assign out_valid = r_out_valid;
  assign ALUResult = r_result;
  assign Zero      = r_zero;

  // Operand signedness: MULHU/DIVU/REMU unsigned, MULHSU signed A only
  assign w_is_mdu   = is_mdu(ALUControl);
  assign w_is_div   = is_div(ALUControl);
  assign w_a_signed = w_is_div ? ~ALUControl[0] : (ALUControl[1:0] != 2'b11);
  assign w_b_signed = w_is_div ? ~ALUControl[0] : ~ALUControl[1];
  assign w_a_neg    = w_a_signed & SrcA[XLEN-1];
  assign w_b_neg    = w_b_signed & SrcB[XLEN-1];
  assign w_a_mag    = w_a_neg ? -SrcA : SrcA;
  assign w_b_mag    = w_b_neg ? -SrcB : SrcB;

  assign w_b_zero      = (SrcB == '0);
  assign w_ovf         = ~ALUControl[0] & (SrcA == MIN_INT) & (SrcB == '1);
  assign w_special     = w_is_div & (w_b_zero | w_ovf);
  assign w_special_res = w_b_zero ? (ALUControl[1] ? SrcA : '1)
                                  : (ALUControl[1] ? '0 : MIN_INT);
  assign w_load_res    = w_special ? w_special_res : w_base;

  // r_acc holds {partial product, multiplier} or {remainder, quotient}
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_trial   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {1'b0, r_b};

  always_comb begin
    w_acc_nxt = r_acc;
    if (is_div(r_op)) begin
      if (!w_trial[XLEN]) begin
        w_acc_nxt = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end else begin
        w_acc_nxt = {r_acc[2*XLEN-2:0], 1'b0};
      end
    end else begin
      w_acc_nxt = {w_mul_sum, r_acc[XLEN-1:1]};
    end
  end

  assign w_prod = r_neg_q ? -w_acc_nxt : w_acc_nxt;
  assign w_quo  = r_neg_q ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
  assign w_rem  = r_neg_r ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];

  always_comb begin
    w_mdu_res = '0;
    if (r_op[2]) begin
      w_mdu_res = r_op[1] ? w_rem : w_quo;
    end else begin
      w_mdu_res = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_b         <= '0;
      r_op        <= 5'd0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        BUSY: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state     <= DONE;
            r_result    <= w_mdu_res;
            r_zero      <= (w_mdu_res == '0);
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        IDLE: ;
        default: r_state <= IDLE;
      endcase

      // A new op overrides the drain of a consumed result (no bubble)
      if (w_accept) begin
        if (w_is_mdu && !w_special) begin
          r_state     <= BUSY;
          r_out_valid <= 1'b0;
          r_cnt       <= SHW'(XLEN-1);
          r_op        <= ALUControl;
          r_neg_q     <= w_a_neg ^ w_b_neg;
          r_neg_r     <= w_a_neg;
          r_acc       <= w_is_div ? {{XLEN{1'b0}}, w_a_mag} : {{XLEN{1'b0}}, w_b_mag};
          r_b         <= w_is_div ? w_b_mag : w_a_mag;
        end else begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
          r_result    <= w_load_res;
          r_zero      <= (w_load_res == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at XLEN=32 and XLEN=64.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  ALUControl = 5'd0;
  logic [31:0] SrcA = 32'd0;
  logic [31:0] SrcB = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] ALUResult;
  logic        Zero;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [4:0]  ALUControl64 = 5'd0;
  logic [63:0] SrcA64 = 64'd0;
  logic [63:0] SrcB64 = 64'd0;
  logic        out_valid64;
  logic        out_ready64 = 1'b0;
  logic [63:0] ALUResult64;
  logic        Zero64;

  int checks = 0;
  int errors = 0;

  alu_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero)
  );

  alu_muldiv #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid64), .in_ready(in_ready64),
    .ALUControl(ALUControl64), .SrcA(SrcA64), .SrcB(SrcB64), .out_valid(out_valid64),
    .out_ready(out_ready64), .ALUResult(ALUResult64), .Zero(Zero64)
  );

  always #5 clk = ~clk;

  // Issue one op on the 32-bit DUT, wait for the result, then consume it
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic rdy_busy);
    ALUControl = op; SrcA = a; SrcB = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; SrcA = $urandom; SrcB = $urandom; ALUControl = 5'b00000;
    lat = 1; rdy_busy = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_busy = 1'b1;
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) lat = -1;
    res = ALUResult;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op64(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat);
    ALUControl64 = op; SrcA64 = a; SrcB64 = b; in_valid64 = 1'b1; out_ready64 = 1'b0;
    @(posedge clk); #1;
    in_valid64 = 1'b0; SrcA64 = {$urandom, $urandom}; SrcB64 = 64'd0;
    lat = 1;
    while (!out_valid64 && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid64) lat = -1;
    res = ALUResult64;
    out_ready64 = 1'b1;
    @(posedge clk); #1;
    out_ready64 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || ALUResult !== 32'd0 || Zero !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_init: ov=%b res=%h z=%b rdy=%b, want ov=0 res=0 z=1 rdy=1",
               out_valid, ALUResult, Zero, in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    // Start a MUL, then reset asynchronously mid-iteration
    ALUControl = 5'b10000; SrcA = 32'd3; SrcB = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ALUResult !== 32'd0 || Zero !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: ov=%b res=%h z=%b rdy=%b, want ov=0 res=0 z=1 rdy=1",
               out_valid, ALUResult, Zero, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    begin
      logic seen = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
        if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_result: out_valid seen=%b want 0", seen);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    ALUControl = 5'b00000; SrcA = 32'd7; SrcB = 32'hFFFF_FFF9; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== 32'd0 || Zero !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_add: ov=%b res=%h z=%b rdy=%b, want ov=1 res=0 z=1 rdy=1",
               out_valid, ALUResult, Zero, in_ready);
    end
    ALUControl = 5'b00010; SrcA = 32'hFFFF_FFFF; SrcB = 32'd1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== 32'd1 || Zero !== 1'b0) begin
      errors++;
      $display("FAIL b2b_slt: ov=%b res=%h z=%b, want ov=1 res=1 z=0", out_valid, ALUResult, Zero);
    end
    ALUControl = 5'b01101; SrcA = 32'h8000_0000; SrcB = 32'h0000_0021;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || ALUResult !== 32'hC000_0000) begin
      errors++;
      $display("FAIL b2b_sra: ov=%b res=%h, want ov=1 res=c0000000", out_valid, ALUResult);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: ov=%b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_base_ops();
    logic [4:0]  ops [9] = '{5'b01000, 5'b00111, 5'b00110, 5'b00100, 5'b00011,
                             5'b00010, 5'b00001, 5'b00101, 5'b01001};
    logic [31:0] as  [9] = '{32'd5, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'hF0F0_00FF, 32'd1,
                             32'd1, 32'd1, 32'h8000_0000, 32'd3};
    logic [31:0] bs  [9] = '{32'd7, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'h0FF0_0F0F, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'h0000_0025, 32'd4, 32'd4};
    logic [31:0] exp [9] = '{32'hFFFF_FFFE, 32'h00F0_000F, 32'hFFF0_0FFF, 32'hFF00_0FF0, 32'd1,
                             32'd0, 32'h0000_0020, 32'h0800_0000, 32'd0};
    logic [31:0] res;
    int lat;
    logic rb;
    for (int i = 0; i < 9; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, rb);
      checks++;
      if (res !== exp[i] || lat != 1) begin
        errors++;
        $display("FAIL base_op%0d: res=%h lat=%0d, want res=%h lat=1", i, res, lat, exp[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [4:0]  ops [4] = '{5'b10001, 5'b10011, 5'b10000, 5'b10010};
    logic [31:0] as  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd2};
    logic [31:0] exp [4] = '{32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFF1, 32'hFFFF_FFFF};
    logic [31:0] res;
    int lat;
    logic rb;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, rb);
      checks++;
      if (res !== exp[i] || lat != 33 || rb !== 1'b0) begin
        errors++;
        $display("FAIL mul%0d: res=%h lat=%0d rdy_busy=%b, want res=%h lat=33 rdy_busy=0",
                 i, res, lat, rb, exp[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [4:0]  ops [6] = '{5'b10100, 5'b10110, 5'b10101, 5'b10111, 5'b10100, 5'b10110};
    logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7};
    logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [31:0] exp [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1};
    logic [31:0] res;
    int lat;
    logic rb;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, rb);
      checks++;
      if (res !== exp[i] || lat != 33) begin
        errors++;
        $display("FAIL div%0d: res=%h lat=%0d, want res=%h lat=33", i, res, lat, exp[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [4:0]  ops [6] = '{5'b10100, 5'b10111, 5'b10100, 5'b10110, 5'b10101, 5'b10110};
    logic [31:0] as  [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
    logic [31:0] bs  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] exp [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] res;
    int lat;
    logic rb;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, rb);
      checks++;
      if (res !== exp[i] || lat != 1) begin
        errors++;
        $display("FAIL special%0d: res=%h lat=%0d, want res=%h lat=1", i, res, lat, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic bad = 1'b0;
    ALUControl = 5'b00000; SrcA = 32'd2; SrcB = 32'd3; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    ALUControl = 5'b00110; SrcA = 32'h1234_0000; SrcB = 32'h0000_5678;
    repeat (10) begin
      if (out_valid !== 1'b1 || ALUResult !== 32'd5 || in_ready !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad !== 1'b0 || ALUResult !== 32'd5) begin
      errors++;
      $display("FAIL hold: res=%h bad=%b, want res=5 stable with rdy=0", ALUResult, bad);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_drain: ov=%b rdy=%b, want ov=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush();
    logic seen = 1'b0;
    ALUControl = 5'b10000; SrcA = 32'd3; SrcB = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; ALUControl = 5'b00000; SrcA = 32'd1; SrcB = 32'd1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy: ov=%b rdy=%b, want ov=0 rdy=1", out_valid, in_ready);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_result: out_valid seen=%b want 0", seen);
    end
    ALUControl = 5'b00000; SrcA = 32'd4; SrcB = 32'd4; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_done: ov=%b rdy=%b, want ov=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_xlen64();
    logic [4:0]  ops [6] = '{5'b10001, 5'b10011, 5'b10000, 5'b10100, 5'b10111, 5'b10100};
    logic [63:0] as  [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
                             64'hFFFF_FFFF_FFFF_FFF9, 64'd100, 64'h8000_0000_0000_0000};
    logic [63:0] bs  [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'hFFFF_FFFF_FFFF_FFFB, 64'd2, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] exp [6] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF1,
                             64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'h8000_0000_0000_0000};
    int          elat [6] = '{65, 65, 65, 65, 65, 1};
    logic [63:0] res;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op64(ops[i], as[i], bs[i], res, lat);
      checks++;
      if (res !== exp[i] || lat != elat[i]) begin
        errors++;
        $display("FAIL x64_op%0d: res=%h lat=%0d, want res=%h lat=%0d", i, res, lat, exp[i], elat[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_base_ops();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_xlen64();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
